// File: rtl/uart16550_regs.sv
// 16550-style UART register file with 16x baud generator, 8N1 TX/RX engines, modem status and interrupts.
// Latency: writes commit on the strobe edge; reads return registered data one edge after the strobe.
// Backpressure: none; the bus side strobes are single-cycle and always accepted.
// Ports: clk/wb_rst_i (async active-low), wb_addr_i/wb_dat_i/wb_we_i/wb_re_i -> wb_dat_o register access,
//        modem_inputs {cts,dsr,ri,dcd}, srx_pad_i serial in, stx_pad_o serial out,
//        rts_pad_o/dtr_pad_o from MCR, int_o interrupt (high while IIR[0]=0).
module uart16550_regs (
  input  logic       clk,
  input  logic       wb_rst_i,
  input  logic [2:0] wb_addr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_re_i,
  input  logic [3:0] modem_inputs,
  output logic       stx_pad_o,
  input  logic       srx_pad_i,
  output logic       rts_pad_o,
  output logic       dtr_pad_o,
  output logic       int_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [3:0]  ier;
  logic [7:0]  lcr;
  logic [4:0]  mcr;
  logic [7:0]  scr, dll, dlm, rbr, thr;
  logic        dr, oe, fe, thre, temt, thre_pend;
  logic [3:0]  modem_q;
  logic        d_cts, d_dsr, teri, d_dcd;

  logic [15:0] baud_cnt;
  logic [15:0] divisor;
  logic        tick;

  logic        tx_busy, tx_line;
  logic [8:0]  tx_shift;
  logic [3:0]  tx_bitcnt, tx_tick;
  logic        tx_load, tx_done;

  logic        rx_s1, rx_s2, rx_s3;
  rx_state_t   rx_state;
  logic [3:0]  rx_tick;
  logic [2:0]  rx_bits;
  logic [7:0]  rx_shift;
  logic        rx_done, rx_fe;

  logic        dlab, wr_thr, wr_ier, rd_rbr, rd_iir, rd_lsr, rd_msr;
  logic [3:0]  modem_chg;
  logic        teri_evt;
  logic [7:0]  lsr, msr, iir, rd_mux;

  assign dlab      = lcr[7];
  assign wr_thr    = wb_we_i && (wb_addr_i == 3'd0) && !dlab;
  assign wr_ier    = wb_we_i && (wb_addr_i == 3'd1) && !dlab;
  assign rd_rbr    = wb_re_i && (wb_addr_i == 3'd0) && !dlab;
  assign rd_iir    = wb_re_i && (wb_addr_i == 3'd2);
  assign rd_lsr    = wb_re_i && (wb_addr_i == 3'd5);
  assign rd_msr    = wb_re_i && (wb_addr_i == 3'd6);

  // modem_inputs = {cts, dsr, ri, dcd}
  assign modem_chg = modem_inputs ^ modem_q;
  assign teri_evt  = modem_q[1] & ~modem_inputs[1];

  assign lsr = {1'b0, temt, thre, 1'b0, fe, 1'b0, oe, dr};
  assign msr = {modem_inputs[0], modem_inputs[1], modem_inputs[2], modem_inputs[3],
                d_dcd, teri, d_dsr, d_cts};

  always_comb begin
    iir = 8'h01;
    if (ier[2] && (oe || fe))
      iir = 8'h06;
    else if (ier[0] && dr)
      iir = 8'h04;
    else if (ier[1] && thre_pend)
      iir = 8'h02;
    else if (ier[3] && (d_cts || d_dsr || teri || d_dcd))
      iir = 8'h00;
  end

  always_comb begin
    rd_mux = 8'h00;
    case (wb_addr_i)
      3'd0: rd_mux = dlab ? dll : rbr;
      3'd1: rd_mux = dlab ? dlm : {4'b0, ier};
      3'd2: rd_mux = iir;
      3'd3: rd_mux = lcr;
      3'd4: rd_mux = {3'b0, mcr};
      3'd5: rd_mux = lsr;
      3'd6: rd_mux = msr;
      3'd7: rd_mux = scr;
      default: rd_mux = 8'h00;
    endcase
  end

  assign int_o     = ~iir[0];
  assign rts_pad_o = mcr[1];
  assign dtr_pad_o = mcr[0];
  assign stx_pad_o = tx_line & ~lcr[6];

  // Baud generator: the counter only reloads from the divisor when it expires,
  // so a divisor change mid-frame lands at the next reload.
  assign divisor = {dlm, dll};
  assign tick    = (divisor != 16'd0) && (baud_cnt == 16'd0);

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i)
      baud_cnt <= 16'd0;
    else if (divisor == 16'd0)
      baud_cnt <= 16'd0;
    else if (baud_cnt == 16'd0)
      baud_cnt <= divisor - 16'd1;
    else
      baud_cnt <= baud_cnt - 16'd1;
  end

  // Transmitter: the load cycle drives the start bit; every bit then lasts 16 ticks.
  assign tx_load = !thre && !tx_busy;
  assign tx_done = tx_busy && tick && (tx_tick == 4'd15) && (tx_bitcnt == 4'd9);

  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      tx_busy   <= 1'b0;
      tx_line   <= 1'b1;
      tx_shift  <= 9'd0;
      tx_bitcnt <= 4'd0;
      tx_tick   <= 4'd0;
    end else if (tx_load) begin
      tx_busy   <= 1'b1;
      tx_line   <= 1'b0;
      tx_shift  <= {1'b1, thr};
      tx_bitcnt <= 4'd0;
      tx_tick   <= 4'd0;
    end else if (tx_busy && tick) begin
      if (tx_tick == 4'd15) begin
        tx_tick <= 4'd0;
        if (tx_bitcnt == 4'd9) begin
          tx_busy <= 1'b0;
          tx_line <= 1'b1;
        end else begin
          tx_line   <= tx_shift[0];
          tx_shift  <= {1'b1, tx_shift[8:1]};
          tx_bitcnt <= tx_bitcnt + 4'd1;
        end
      end else begin
        tx_tick <= tx_tick + 4'd1;
      end
    end
  end

  // Receiver: rx_s3 is the previous synchronised sample, used only for edge detection.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_tick  <= 4'd0;
      rx_bits  <= 3'd0;
      rx_shift <= 8'd0;
      rx_done  <= 1'b0;
      rx_fe    <= 1'b0;
    end else begin
      rx_s1   <= srx_pad_i;
      rx_s2   <= rx_s1;
      rx_s3   <= rx_s2;
      rx_done <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_state <= RX_START;
            rx_tick  <= 4'd0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tick == 4'd7) begin
              rx_tick <= 4'd0;
              rx_bits <= 3'd0;
              // still high at mid start bit: treat as a glitch
              rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick <= rx_tick + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (rx_tick == 4'd15) begin
              rx_tick  <= 4'd0;
              rx_shift <= {rx_s2, rx_shift[7:1]};
              if (rx_bits == 3'd7)
                rx_state <= RX_STOP;
              else
                rx_bits <= rx_bits + 3'd1;
            end else begin
              rx_tick <= rx_tick + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (rx_tick == 4'd15) begin
              rx_tick  <= 4'd0;
              rx_done  <= 1'b1;
              rx_fe    <= ~rx_s2;
              rx_state <= RX_IDLE;
            end else begin
              rx_tick <= rx_tick + 4'd1;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Register file and status. Where an event and a clearing read meet on
  // the same edge the event wins.
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ier       <= 4'd0;
      lcr       <= 8'h03;
      mcr       <= 5'd0;
      scr       <= 8'd0;
      dll       <= 8'd0;
      dlm       <= 8'd0;
      rbr       <= 8'd0;
      thr       <= 8'd0;
      wb_dat_o  <= 8'd0;
      dr        <= 1'b0;
      oe        <= 1'b0;
      fe        <= 1'b0;
      thre      <= 1'b1;
      temt      <= 1'b1;
      thre_pend <= 1'b0;
      modem_q   <= 4'd0;
      d_cts     <= 1'b0;
      d_dsr     <= 1'b0;
      teri      <= 1'b0;
      d_dcd     <= 1'b0;
    end else begin
      if (wb_we_i) begin
        case (wb_addr_i)
          3'd0: if (dlab) dll <= wb_dat_i; else thr <= wb_dat_i;
          3'd1: if (dlab) dlm <= wb_dat_i; else ier <= wb_dat_i[3:0];
          3'd3: lcr <= wb_dat_i;
          3'd4: mcr <= wb_dat_i[4:0];
          3'd7: scr <= wb_dat_i;
          default: ;
        endcase
      end
      if (wb_re_i)
        wb_dat_o <= rd_mux;

      // A THR write on the load edge refills THR, so THRE never rises there.
      if (wr_thr)
        thre <= 1'b0;
      else if (tx_load)
        thre <= 1'b1;

      if (tx_load)
        temt <= 1'b0;
      else if (tx_done && thre && !wr_thr)
        temt <= 1'b1;

      thre_pend <= (tx_load && !wr_thr) ||
                   (wr_ier && wb_dat_i[1] && thre) ||
                   (thre_pend && !wr_thr && !(rd_iir && (iir == 8'h02)));

      if (rx_done)
        rbr <= rx_shift;
      dr <= rx_done || (dr && !rd_rbr);
      oe <= (rx_done && dr && !rd_rbr) || (oe && !rd_lsr);
      fe <= (rx_done && rx_fe) || (fe && !rd_lsr);

      modem_q <= modem_inputs;
      d_cts   <= modem_chg[3] || (d_cts && !rd_msr);
      d_dsr   <= modem_chg[2] || (d_dsr && !rd_msr);
      teri    <= teri_evt     || (teri  && !rd_msr);
      d_dcd   <= modem_chg[0] || (d_dcd && !rd_msr);
    end
  end

endmodule

// File: tb/tb_uart16550_regs.sv
// Self-checking bench for uart16550_regs: register model plus per-cycle serial line checks.
// Latency: bus reads complete one clock after the strobe; serial frames run at divisor 1.
// Backpressure: none; stimulus drives single-cycle strobes.
module tb_uart16550_regs;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [2:0] wb_addr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_we_i, wb_re_i;
  logic [3:0] modem_inputs;
  logic       stx_pad_o, srx_pad_i, rts_pad_o, dtr_pad_o, int_o;

  uart16550_regs dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_re_i(wb_re_i),
    .modem_inputs(modem_inputs), .stx_pad_o(stx_pad_o), .srx_pad_i(srx_pad_i),
    .rts_pad_o(rts_pad_o), .dtr_pad_o(dtr_pad_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, want 0x%02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_lcr, m_scr, m_dll, m_dlm, m_rbr, tx_data;
  logic [3:0] m_ier, m_modem, m_delta;  // m_delta: {dDCD, TERI, dDSR, dCTS}
  logic [4:0] m_mcr;
  logic       m_dr, m_oe, m_fe, m_pend;
  int         tx_w;                     // cycle of the last THR write edge

  task automatic model_reset();
    m_lcr = 8'h03; m_scr = 8'h00; m_dll = 8'h00; m_dlm = 8'h00; m_rbr = 8'h00;
    m_ier = 4'h0; m_mcr = 5'h00; m_delta = 4'h0;
    m_dr = 1'b0; m_oe = 1'b0; m_fe = 1'b0; m_pend = 1'b0;
    tx_w = -1000; tx_data = 8'hFF;
  endtask

  // A frame takes 160 clocks at divisor 1 and starts one clock after the write.
  function automatic logic model_temt();
    return cyc >= tx_w + 161;
  endfunction

  function automatic logic [7:0] model_iir();
    if (m_ier[2] && (m_oe || m_fe)) return 8'h06;
    if (m_ier[0] && m_dr)           return 8'h04;
    if (m_ier[1] && m_pend)         return 8'h02;
    if (m_ier[3] && (m_delta != 4'h0)) return 8'h00;
    return 8'h01;
  endfunction

  function automatic logic [7:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return m_lcr[7] ? m_dll : m_rbr;
      3'd1: return m_lcr[7] ? m_dlm : {4'h0, m_ier};
      3'd2: return model_iir();
      3'd3: return m_lcr;
      3'd4: return {3'b0, m_mcr};
      3'd5: return {1'b0, model_temt(), 1'b1, 1'b0, m_fe, 1'b0, m_oe, m_dr};
      3'd6: return {m_modem[0], m_modem[1], m_modem[2], m_modem[3], m_delta};
      default: return m_scr;
    endcase
  endfunction

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // ---------------- per-cycle output compare ----------------
  logic chk_en = 1'b0;
  logic e_stx;
  int   k_off;
  always @(negedge clk) begin
    if (chk_en) begin
      k_off = cyc - (tx_w + 1);
      if (m_lcr[6])                     e_stx = 1'b0;
      else if (k_off >= 0 && k_off < 160) e_stx = frame_bit(tx_data, k_off / 16);
      else                              e_stx = 1'b1;
      check("stx_line", {7'b0, stx_pad_o}, {7'b0, e_stx});
      check("rts", {7'b0, rts_pad_o}, {7'b0, m_mcr[1]});
      check("dtr", {7'b0, dtr_pad_o}, {7'b0, m_mcr[0]});
    end
  end

  // ---------------- bus / line tasks ----------------
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    wb_addr_i = a; wb_dat_i = d; wb_we_i = 1'b1;
    @(posedge clk); #1;
    wb_we_i = 1'b0;
    case (a)
      3'd0: if (m_lcr[7]) m_dll = d; else begin tx_w = cyc; tx_data = d; m_pend = 1'b1; end
      3'd1: if (m_lcr[7]) m_dlm = d; else begin m_ier = d[3:0]; if (d[1]) m_pend = 1'b1; end
      3'd3: m_lcr = d;
      3'd4: m_mcr = d[4:0];
      3'd7: m_scr = d;
      default: ;
    endcase
  endtask

  task automatic rd(input logic [2:0] a, input string name, output logic [7:0] v);
    logic [7:0] e;
    @(negedge clk);
    e = model_read(a);
    wb_addr_i = a; wb_re_i = 1'b1;
    @(posedge clk); #1;
    wb_re_i = 1'b0;
    v = wb_dat_o;
    check(name, v, e);
    case (a)
      3'd0: if (!m_lcr[7]) m_dr = 1'b0;
      3'd2: if (e == 8'h02) m_pend = 1'b0;
      3'd5: begin m_oe = 1'b0; m_fe = 1'b0; end
      3'd6: m_delta = 4'h0;
      default: ;
    endcase
  endtask

  task automatic chk_int(input string name);
    logic [7:0] e;
    e = model_iir();
    check(name, {7'b0, int_o}, {7'b0, ~e[0]});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      srx_pad_i = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    srx_pad_i = 1'b1;
    if (m_dr) m_oe = 1'b1;
    m_dr = 1'b1;
    m_rbr = b;
    if (!stop) m_fe = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_modem(input logic [3:0] v);
    @(negedge clk);
    if (v[3] != m_modem[3]) m_delta[0] = 1'b1;
    if (v[2] != m_modem[2]) m_delta[1] = 1'b1;
    if (m_modem[1] && !v[1]) m_delta[2] = 1'b1;
    if (v[0] != m_modem[0]) m_delta[3] = 1'b1;
    modem_inputs = v;
    m_modem = v;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
    $fatal(1);
  end

  logic [7:0] v;
  logic [7:0] r [8];
  int exp_bits [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

  initial begin
    wb_rst_i = 1'b0; wb_addr_i = 3'd0; wb_dat_i = 8'h00; wb_we_i = 1'b0; wb_re_i = 1'b0;
    modem_inputs = 4'h0; m_modem = 4'h0; srx_pad_i = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check("rst_stx", {7'b0, stx_pad_o}, 8'h01);
    check("rst_int", {7'b0, int_o}, 8'h00);
    check("rst_dat_o", wb_dat_o, 8'h00);
    check("rst_rts_dtr", {6'b0, rts_pad_o, dtr_pad_o}, 8'h00);
    wb_rst_i = 1'b1;
    chk_en = 1'b1;

    for (int a = 0; a < 8; a++) rd(a[2:0], $sformatf("rst_rd%0d", a), r[a]);
    check("iir_rst_lit", r[2], 8'h01);
    check("lcr_rst_lit", r[3], 8'h03);
    check("lsr_rst_lit", r[5], 8'h60);

    // scratch, modem control, IER width
    wr(3'd7, 8'hA7); rd(3'd7, "scr", v); check("scr_lit", v, 8'hA7);
    wr(3'd4, 8'hFF); rd(3'd4, "mcr", v); check("mcr_lit", v, 8'h1F);
    wr(3'd4, 8'h02); repeat (2) @(negedge clk);
    wr(3'd1, 8'hF5); rd(3'd1, "ier", v); check("ier_lit", v, 8'h05);
    wr(3'd1, 8'h00);

    // divisor latch access
    wr(3'd3, 8'h83); wr(3'd0, 8'h01); wr(3'd1, 8'h00);
    rd(3'd0, "dll", v); check("dll_lit", v, 8'h01);
    rd(3'd1, "dlm", v);
    rd(3'd3, "lcr83", v); check("lcr83_lit", v, 8'h83);
    wr(3'd3, 8'h03);
    rd(3'd0, "rbr_not_dll", v); check("rbr_not_dll_lit", v, 8'h00);

    // transmit 0x55: mid-bit literal samples of the serial line
    wr(3'd0, 8'h55);
    for (int b = 0; b < 10; b++) begin
      while (cyc < tx_w + 9 + 16 * b) @(negedge clk);
      check($sformatf("tx55_bit%0d", b), {7'b0, stx_pad_o}, exp_bits[b][7:0]);
    end
    rd(3'd5, "lsr_busy", v); check("lsr_busy_lit", v, 8'h20);
    while (cyc < tx_w + 166) @(negedge clk);
    rd(3'd5, "lsr_done", v); check("lsr_done_lit", v, 8'h60);

    // THRE interrupt: pending from THRE rising, cleared by IIR read, re-armed by IER write
    wr(3'd1, 8'h02); chk_int("int_thre");
    rd(3'd2, "iir_thre", v); check("iir_thre_lit", v, 8'h02);
    rd(3'd2, "iir_thre_clr", v); check("iir_thre_clr_lit", v, 8'h01);
    chk_int("int_thre_clr");
    wr(3'd1, 8'h00); wr(3'd1, 8'h02);
    rd(3'd2, "iir_thre_rearm", v);
    wr(3'd1, 8'h00);

    // receive 0xA5
    send_byte(8'hA5, 1'b1);
    rd(3'd5, "lsr_rx", v); check("lsr_rx_lit", v, 8'h61);
    rd(3'd0, "rbr_a5", v); check("rbr_a5_lit", v, 8'hA5);
    rd(3'd5, "lsr_rx_clr", v); check("lsr_rx_clr_lit", v, 8'h60);

    // overrun and line-status priority
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    wr(3'd1, 8'h05); chk_int("int_oe");
    rd(3'd2, "iir_oe", v); check("iir_oe_lit", v, 8'h06);
    rd(3'd5, "lsr_oe", v); check("lsr_oe_lit", v, 8'h63);
    rd(3'd2, "iir_rda", v); check("iir_rda_lit", v, 8'h04);
    rd(3'd0, "rbr_c3", v); check("rbr_c3_lit", v, 8'hC3);
    rd(3'd2, "iir_none", v);
    chk_int("int_none");

    // framing error
    send_byte(8'h81, 1'b0);
    rd(3'd2, "iir_fe", v); check("iir_fe_lit", v, 8'h06);
    rd(3'd5, "lsr_fe", v); check("lsr_fe_lit", v, 8'h69);
    rd(3'd0, "rbr_81", v);
    rd(3'd5, "lsr_fe_clr", v);
    wr(3'd1, 8'h00);

    // short low glitch must not produce a byte
    @(negedge clk); srx_pad_i = 1'b0;
    repeat (3) @(negedge clk); srx_pad_i = 1'b1;
    repeat (40) @(negedge clk);
    rd(3'd5, "lsr_glitch", v); check("lsr_glitch_lit", v, 8'h60);

    // modem status
    wr(3'd1, 8'h08);
    set_modem(4'b1000); chk_int("int_msr");
    rd(3'd2, "iir_msr", v); check("iir_msr_lit", v, 8'h00);
    rd(3'd6, "msr_dcts", v); check("msr_dcts_lit", v, 8'h11);
    rd(3'd6, "msr_clr", v); check("msr_clr_lit", v, 8'h10);
    chk_int("int_msr_clr");
    set_modem(4'b1010); rd(3'd6, "msr_ri_rise", v); check("msr_ri_rise_lit", v, 8'h50);
    set_modem(4'b1000); rd(3'd6, "msr_teri", v); check("msr_teri_lit", v, 8'h14);
    set_modem(4'b0000); rd(3'd6, "msr_cts_fall", v);
    rd(3'd6, "msr_idle", v);
    wr(3'd1, 8'h00);

    // break forces the line low
    wr(3'd3, 8'h43); repeat (5) @(negedge clk);
    wr(3'd3, 8'h03); repeat (2) @(negedge clk);

    // reset in the middle of a frame
    wr(3'd0, 8'hAA);
    while (cyc < tx_w + 40) @(negedge clk);
    #2;
    wb_rst_i = 1'b0;
    model_reset();
    @(negedge clk);
    check("mid_rst_stx", {7'b0, stx_pad_o}, 8'h01);
    check("mid_rst_dat_o", wb_dat_o, 8'h00);
    check("mid_rst_int", {7'b0, int_o}, 8'h00);
    repeat (2) @(negedge clk);
    wb_rst_i = 1'b1;
    for (int a = 0; a < 8; a++) rd(a[2:0], $sformatf("post_rst_rd%0d", a), r[a]);
    check("post_rst_lsr_lit", r[5], 8'h60);
    check("post_rst_scr_lit", r[7], 8'h00);
    repeat (4) @(negedge clk);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart16550_regs.md
# uart16550_regs

Register file and serial engine of the 16550-compatible UART: eight byte-wide registers at offsets 0–7, a 16× baud generator, an 8N1 transmitter and receiver (single holding register each, no FIFO), modem-status tracking and a prioritised interrupt output. It sits below the APB bridge, which drives single-cycle read/write strobes with a 3-bit address and byte data.

## Interface
- No parameters.
- clk  in  1  system clock; all state on rising edge
- wb_rst_i  in  1  asynchronous, active-low reset
- wb_addr_i  in  3  register offset
- wb_dat_i  in  8  write data; valid in the wb_we_i cycle
- wb_dat_o  out  8  registered read data
- wb_we_i  in  1  one-cycle write strobe
- wb_re_i  in  1  one-cycle read strobe
- modem_inputs  in  4  {cts, dsr, ri, dcd}, active-high
- stx_pad_o  out  1  serial TX, idle high
- srx_pad_i  in  1  serial RX, asynchronous
- rts_pad_o  out  1  MCR[1]
- dtr_pad_o  out  1  MCR[0]
- int_o  out  1  interrupt, active-high

## Operation
- DLAB = LCR[7]. Offset 0: read RBR / write THR (DLAB=1: DLL). Offset 1: IER[3:0] (DLAB=1: DLM). Offset 2: read IIR / write FCR (accepted, no effect). Offset 3: LCR. Offset 4: MCR[4:0]. Offset 5: LSR (read-only). Offset 6: MSR (read-only). Offset 7: SCR.
- Reset values: IER=0, IIR=0x01, LCR=0x03, MCR=0, LSR=0x60, MSR[3:0]=0, SCR=0, DLL=DLM=0, RBR=0, wb_dat_o=0, stx_pad_o=1, rts/dtr=0, int_o=0.
- Frame fixed 8N1 regardless of LCR[5:0] (stored and readable only). LCR[6]=1 forces stx_pad_o=0.
- Baud: divisor D={DLM,DLL}; D=0 stops ticks. Otherwise one 16× tick every D clocks; bit time = 16 ticks.
- LSR: [0] DR, [1] OE, [2] PE=0, [3] FE, [4] BI=0, [5] THRE, [6] TEMT, [7]=0. LSR read clears OE, FE.
- TX: THR write clears THRE. When shifter idle and THR full, THR moves to shifter next clock; THRE=1, TEMT=0. Sends start 0, data LSB first, stop 1, each 16 ticks; TEMT=1 when stop bit ends and THR empty.
- RX: srx two-flop synchronised. Falling edge starts; re-check at 8 ticks (high → abort, glitch). Then sample every 16 ticks: 8 data bits, stop. Stop sample 0 → FE=1. Byte written to RBR, DR=1; if DR already 1, OE=1 and RBR overwritten. RBR read clears DR.
- MSR[7:4] = {dcd, ri, dsr, cts} current; MSR[0] dCTS, [1] dDSR, [3] dDCD set on any change, [2] TERI on ri 1→0; deltas cleared by MSR read.
- Interrupt priority, IIR value: line status (IER[2] & (OE|FE)) 0x06; RX data (IER[0] & DR) 0x04; THRE (IER[1] & thre_pend) 0x02; modem (IER[3] & any delta) 0x00; none 0x01. thre_pend sets on THRE rising or IER[1] write with THRE=1; clears on THR write or IIR read returning 0x02. int_o = ~IIR[0].

## Timing
- Write commits at edge where wb_we_i=1.
- Read: at edge where wb_re_i=1, wb_dat_o captures addressed register; held until next read. Read side-effects apply at the same edge.
- Simultaneous RX completion and RBR read: new byte wins, DR=1, no OE.
- Simultaneous event set and clearing read: set wins.
- THR write while THRE=0 overwrites THR.
- Divisor write mid-frame takes effect at next tick-counter reload.
- Reset asserted mid-frame: immediate return to reset values, line idle high.

## Test plan
- Reset, read all offsets -> IIR 0x01, LCR 0x03, LSR 0x60, others 0.
- LCR=0x83, DLL=0x01, DLM=0x00, read back; LCR=0x03, read offset 0 -> RBR (0x00), not DLL.
- D=1, write THR=0x55 -> stx low 16 clocks, then 1,0,1,0,1,0,1,0 each 16 clocks, stop high; TEMT=1 at ~160 clocks.
- Drive 0xA5 8N1 at D=1 on srx -> LSR=0x61, RBR read 0xA5, LSR then 0x60.
- Two bytes without reading -> LSR OE=1; IER=0x05 -> IIR 0x06, int_o=1; LSR read -> IIR 0x04.
- Toggle cts with IER=0x08 -> MSR=0x11, IIR 0x00; MSR read -> MSR=0x10, int_o=0.
